alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter BW, default 4: datapath bitwidth of operands and result.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 req_valid[1:0]  in  2  per-requester operation request.
REQ-005 req_ready[1:0]  out  2  per-requester accept; handshake completes on the edge where valid and ready are both high.
REQ-006 req_opcode0, req_opcode1  in  3 each  operation code, encoded as in the shared ALU package.
REQ-007 req_a0, req_a1, req_b0, req_b1  in  BW each  operands.
REQ-008 resp_valid[1:0]  out  2  result available for that requester.
REQ-009 resp_ready[1:0]  in  2  requester accepts the result.
REQ-010 resp_out  out  BW  result, shared by both requesters and meaningful only where resp_valid is high.
REQ-011 resp_flags  out  3  {overflow, negative, zero} of resp_out.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 op_count  out  8  count of completed operations.

Function
REQ-014 The block shall be a three-state FSM (IDLE, EXEC, RESP) that shares one ALU instance between two requesters.
REQ-015 IDLE behaviour:
- If any req_valid is high, the block shall grant exactly one requester.
- It shall drive that requester's req_ready high combinationally in the same cycle.
- On that edge it shall capture the opcode, a and b, record the grant index, and go to EXEC.
REQ-016 Grant rule:
- If only one req_valid is high, that requester shall be granted regardless of priority.
- If both are high, the requester named by the priority pointer (rr_ptr) shall be granted.
REQ-017 req_ready shall be low in EXEC and RESP, and shall never be high for both requesters at once.
REQ-018 EXEC behaviour: the captured operands and opcode shall drive the ALU, the ALU result and flags shall be registered into resp_out/resp_flags, and the FSM shall go to RESP after exactly one cycle.
REQ-019 RESP behaviour:
- resp_valid[grant] shall be high and the other bit low.
- resp_out and resp_flags shall be held stable until resp_ready[grant] is high.
- On that edge the FSM shall return to IDLE, set rr_ptr to the requester not just served, and increment op_count.
REQ-020 Latency: an accept at edge N shall produce resp_valid high from cycle N+2; peak throughput is one operation per 3 cycles.
REQ-021 A new request shall not be accepted in the cycle a response completes; acceptance resumes in IDLE on the following cycle.
REQ-022 op_count shall wrap modulo 256 (255 -> 0).
REQ-023 ALU semantics (BW-bit, wrap-around arithmetic):
- 000 ADD: out = a+b; overflow set on signed overflow.
- 001 SUB: out = a-b; overflow set on signed overflow.
- 010 AND, 011 OR, 100 XOR: bitwise; overflow = 0.
- 101 INC: out = a+1; overflow = 0.
- 110 PASS A: out = a; overflow = 0.
- 111 PASS B: out = b; overflow = 0.
- For all opcodes: negative = out[BW-1], zero = (out == 0).
REQ-024 The 3-bit request opcode shall be zero-extended to the ALU's 4-bit opcode port.
REQ-025 Changes on req_* inputs after acceptance shall not affect the operation in flight.

Reset
REQ-026 Asserting rst_n low shall take effect immediately, in any state including mid-EXEC or mid-RESP:
- FSM goes to IDLE; rr_ptr and grant go to 0; op_count goes to 0.
- resp_out and resp_flags go to 0; req_ready, resp_valid and busy go low.
- Any in-flight operation is discarded and no response is issued for it.
REQ-027 After release, the first edge with a valid request shall be able to accept it.

Structure
REQ-028 Shared package alu_pkg shall hold:
- the opcode enum (3-bit);
- flag index constants OVF=2, NEG=1, ZERO=0;
- the FSM state enum;
- the default BW.
REQ-029 The block shall instantiate the existing alu module as its single sub-module; no other arithmetic shall exist in alu_arbiter.

Verification (BW=4)
REQ-030 Requester 0, ADD a=0111 b=0001, resp_ready held high -> resp_valid[0] at accept+2, resp_out=1000, flags=110.
REQ-031 Requester 1, SUB a=0011 b=0011 -> resp_valid[1], resp_out=0000, flags=001; op_count increments by 1.
REQ-032 Both valid on the first cycle after reset (r0 XOR 1010^0110, r1 INC 1111) -> r0 served first with out=1100, flags=010; then r1 with out=0000, flags=001.
REQ-033 resp_ready held low for 3 cycles in RESP -> resp_out, resp_flags and resp_valid stable; req_ready=00 throughout; busy=1.
REQ-034 rst_n pulsed low during EXEC -> outputs immediately at reset values, no resp_valid afterwards, op_count=0.
REQ-035 256 back-to-back PASS B operations -> op_count wraps to 0, and grants alternate whenever both requesters are valid.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, flag indices, arbiter FSM states.
// Imported by alu and alu_arbiter.
package alu_pkg;

  localparam int BW_DEF = 4;

  localparam int OVF  = 2;
  localparam int NEG  = 1;
  localparam int ZERO = 0;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_INC   = 3'b101,
    OP_PASSA = 3'b110,
    OP_PASSB = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/alu.sv
// Combinational BW-bit ALU with {overflow, negative, zero} flags.
// Ports: i_op (4b, top bit reserved -> result 0), i_a, i_b, o_out, o_flags.
module alu
  import alu_pkg::*;
#(
  parameter int BW = BW_DEF
) (
  input  logic [3:0]    i_op,
  input  logic [BW-1:0] i_a,
  input  logic [BW-1:0] i_b,
  output logic [BW-1:0] o_out,
  output logic [2:0]    o_flags
);

  logic [BW-1:0] w_out;
  logic          w_ovf;
  logic          w_sa;
  logic          w_sb;
  logic          w_so;

  assign w_sa = i_a[BW-1];
  assign w_sb = i_b[BW-1];
  assign w_so = w_out[BW-1];

  always_comb begin
    w_out = '0;
    w_ovf = 1'b0;
    if (!i_op[3]) begin
      unique case (op_e'(i_op[2:0]))
        OP_ADD: begin
          w_out = i_a + i_b;
          w_ovf = (w_sa == w_sb) && (w_so != w_sa);
        end
        OP_SUB: begin
          w_out = i_a - i_b;
          w_ovf = (w_sa != w_sb) && (w_so != w_sa);
        end
        OP_AND:   w_out = i_a & i_b;
        OP_OR:    w_out = i_a | i_b;
        OP_XOR:   w_out = i_a ^ i_b;
        OP_INC:   w_out = i_a + 1'b1;
        OP_PASSA: w_out = i_a;
        OP_PASSB: w_out = i_b;
      endcase
    end
  end

  always_comb begin
    o_out         = w_out;
    o_flags       = '0;
    o_flags[OVF]  = w_ovf;
    o_flags[NEG]  = w_out[BW-1];
    o_flags[ZERO] = (w_out == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one ALU: IDLE -> EXEC -> RESP.
// Ports: req_* request side, resp_* response side, busy, op_count.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int BW = BW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [2:0]    req_opcode0,
  input  logic [2:0]    req_opcode1,
  input  logic [BW-1:0] req_a0,
  input  logic [BW-1:0] req_a1,
  input  logic [BW-1:0] req_b0,
  input  logic [BW-1:0] req_b1,
  output logic [1:0]    resp_valid,
  input  logic [1:0]    resp_ready,
  output logic [BW-1:0] resp_out,
  output logic [2:0]    resp_flags,
  output logic          busy,
  output logic [7:0]    op_count
);

  state_e        r_state;
  state_e        w_next;
  logic          r_grant;
  logic          r_rr;
  logic [2:0]    r_op;
  logic [BW-1:0] r_a;
  logic [BW-1:0] r_b;
  logic [BW-1:0] r_out;
  logic [2:0]    r_flags;
  logic [7:0]    r_cnt;
  logic          w_gnt;
  logic          w_accept;
  logic          w_done;
  logic [BW-1:0] w_alu_out;
  logic [2:0]    w_alu_flags;

  // A lone request wins outright; the pointer only breaks ties.
  assign w_gnt = (&req_valid) ? r_rr : req_valid[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    busy       = 1'b1;
    w_accept   = 1'b0;
    w_done     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (|req_valid) begin
          w_accept         = 1'b1;
          req_ready[w_gnt] = 1'b1;
          w_next           = S_EXEC;
        end
      end
      S_EXEC: w_next = S_RESP;
      S_RESP: begin
        resp_valid[r_grant] = 1'b1;
        if (resp_ready[r_grant]) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant <= 1'b0;
      r_rr    <= 1'b0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_out   <= '0;
      r_flags <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_grant <= w_gnt;
        r_op    <= w_gnt ? req_opcode1 : req_opcode0;
        r_a     <= w_gnt ? req_a1 : req_a0;
        r_b     <= w_gnt ? req_b1 : req_b0;
      end
      if (r_state == S_EXEC) begin
        r_out   <= w_alu_out;
        r_flags <= w_alu_flags;
      end
      if (w_done) begin
        r_rr  <= ~r_grant;
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  alu #(
    .BW(BW)
  ) u_alu (
    .i_op    ({1'b0, r_op}),
    .i_a     (r_a),
    .i_b     (r_b),
    .o_out   (w_alu_out),
    .o_flags (w_alu_flags)
  );

  assign resp_out   = r_out;
  assign resp_flags = r_flags;
  assign op_count   = r_cnt;

endmodule
